ads124x_rdata_reader: RTL and testbench

DRDY-driven conversion reader for the ADS124x ADC, and the producer of the 32-bit sample stream on the `m_axis` port of `axi_ads124x`. On each DRDY falling edge it runs one SPI read-data-by-command frame (RDATA 0x12 plus 24 read bits) in SPI mode 1. It sign-extends the 24-bit result to 32 bits and presents it on a single-entry AXI4-Stream output register. It sits between the ADS124x SPI/GPIO pins and the downstream stream consumer.

---
 rtl/ads124x_rdata_reader_if.sv | 9 +
 rtl/ads124x_rdata_reader.sv | 215 +++++++++++++++++++++
 tb/tb_ads124x_rdata_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads124x_rdata_reader_if.sv
// Single-entry AXI4-Stream sample port between the ADS124x reader and its consumer.
interface ads124x_rdata_reader_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ads124x_rdata_reader.sv
// DRDY-driven ADS124x RDATA reader: one SPI mode-1 frame per DRDY fall, sign-extended sample on AXI-Stream.
// Optional feature: define ADS124X_SEQ_TAG_EN to put an 8-bit handshake sequence number in tdata[31:24].
module ads124x_rdata_reader #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          DRDY,
    output logic                          SCK_O,
    output logic                          SS_O,
    output logic                          IO0_O,
    input  logic                          IO1_I,
    ads124x_rdata_reader_if.master        m_axis,
    output logic                          busy,
    output logic [15:0]                   drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_OUT
    } state_t;

    // RDATA opcode followed by three dummy bytes that keep DIN high while data clocks out.
    localparam logic [31:0] TX_FRAME    = 32'h12FF_FFFF;
    localparam logic [8:0]  HALF_LAST   = 9'(CLK_DIV - 1);
    localparam logic [8:0]  PERIOD_LAST = 9'(2 * CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] tx_q, tx_d;
    logic [23:0] rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        ss_q, ss_d;
    logic        mosi_q, mosi_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic [15:0] drop_q, drop_d;
    logic        busy_q, busy_d;
    logic        meta_q, meta_d;
    logic        sync_q, sync_d;
    logic        dly_q, dly_d;
    logic        fall_q, fall_d;
`ifdef ADS124X_SEQ_TAG_EN
    logic [7:0]  seq_q, seq_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sck_d    = sck_q;
        ss_d     = ss_q;
        mosi_d   = mosi_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        drop_d   = drop_q;
`ifdef ADS124X_SEQ_TAG_EN
        seq_d    = seq_q;
`endif

        meta_d = DRDY;
        sync_d = meta_q;
        dly_d  = sync_q;
        // Registered edge pulse keeps DRDY decoding off the state-transition path.
        fall_d = dly_q & ~sync_q;

        if (fall_q && enable && (state_q != S_IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall_q && enable) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    ss_d    = 1'b0;
                    sck_d   = 1'b0;
                end
            end

            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                    mosi_d  = TX_FRAME[31];
                    tx_d    = {TX_FRAME[30:0], 1'b0};
                    rx_d    = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            S_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    // Sample DOUT on the edge that drops SCK; the first 8 samples fall off the top.
                    sck_d = 1'b0;
                    rx_d  = {rx_q[22:0], IO1_I};
                    cnt_d = cnt_q + 9'd1;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd31) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sck_d  = 1'b1;
                        mosi_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            S_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    state_d  = S_OUT;
                    cnt_d    = '0;
                    ss_d     = 1'b1;
                    mosi_d   = 1'b0;
                    tvalid_d = 1'b1;
`ifdef ADS124X_SEQ_TAG_EN
                    tdata_d  = {seq_q, rx_q};
`else
                    tdata_d  = {{8{rx_q[23]}}, rx_q};
`endif
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            S_OUT: begin
                if (m_axis.tready) begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
`ifdef ADS124X_SEQ_TAG_EN
                    seq_d    = seq_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d  = S_IDLE;
                ss_d     = 1'b1;
                sck_d    = 1'b0;
                tvalid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            drop_q   <= '0;
            busy_q   <= 1'b0;
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            dly_q    <= 1'b1;
            fall_q   <= 1'b0;
`ifdef ADS124X_SEQ_TAG_EN
            seq_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sck_q    <= sck_d;
            ss_q     <= ss_d;
            mosi_q   <= mosi_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            drop_q   <= drop_d;
            busy_q   <= busy_d;
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            dly_q    <= dly_d;
            fall_q   <= fall_d;
`ifdef ADS124X_SEQ_TAG_EN
            seq_q    <= seq_d;
`endif
        end
    end

    assign SCK_O         = sck_q;
    assign SS_O          = ss_q;
    assign IO0_O         = mosi_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign busy          = busy_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_ads124x_rdata_reader.sv
// Randomized self-checking bench for ads124x_rdata_reader with an SPI/ADC pin-level model.
module tb_ads124x_rdata_reader;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        DRDY = 1'b1;
    logic        IO1_I = 1'b0;
    logic        SCK_O, SS_O, IO0_O, busy;
    logic [15:0] drop_count;

    ads124x_rdata_reader_if axis ();

    ads124x_rdata_reader #(.CLK_DIV(CLK_DIV)) dut (
        .aclk       (clk),
        .aresetn    (aresetn),
        .enable     (enable),
        .DRDY       (DRDY),
        .SCK_O      (SCK_O),
        .SS_O       (SS_O),
        .IO0_O      (IO0_O),
        .IO1_I      (IO1_I),
        .m_axis     (axis.master),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the ADC will return and what the counters should read.
    logic [23:0] adc_word = 24'h0;
    logic [15:0] exp_drops = 16'h0;
`ifdef ADS124X_SEQ_TAG_EN
    logic [7:0]  exp_seq = 8'h0;
`endif

    // Pin monitor + ADC DOUT model, sampled on the falling aclk edge.
    bit          prev_ss = 1'b1;
    bit          prev_sck = 1'b0;
    int          live_low, live_rises, live_high, live_bad;
    logic [31:0] live_mosi;
    int          mon_frames = 0;
    int          mon_ss_low = 0;
    int          mon_rises = 0;
    int          mon_sck_bad = 0;
    logic [31:0] mon_mosi = 32'h0;

    always @(negedge clk) begin
        logic [31:0] dout_word;
        if (prev_ss && !SS_O) begin
            live_low = 0; live_rises = 0; live_high = 0; live_bad = 0; live_mosi = 32'h0;
            mon_frames++;
        end
        if (!SS_O) live_low++;
        if (SCK_O) begin
            if (!prev_sck) begin
                dout_word = {8'h00, adc_word};
                if (live_rises < 32) IO1_I = dout_word[31 - live_rises];
                live_rises++;
                live_high = 0;
            end
            live_high++;
        end else if (prev_sck) begin
            live_mosi = {live_mosi[30:0], IO0_O};
            if (live_high != CLK_DIV) live_bad++;
        end
        if (!prev_ss && SS_O) begin
            mon_ss_low  = live_low;
            mon_mosi    = live_mosi;
            mon_rises   = live_rises;
            mon_sck_bad = live_bad;
        end
        prev_ss  = SS_O;
        prev_sck = SCK_O;
    end

    function automatic logic [31:0] model_sample(input logic [23:0] w);
`ifdef ADS124X_SEQ_TAG_EN
        return {exp_seq, w};
`else
        int v;
        v = (int'(w) >= 8388608) ? int'(w) - 16777216 : int'(w);
        return 32'(v);
`endif
    endfunction

    task automatic note_handshake();
`ifdef ADS124X_SEQ_TAG_EN
        exp_seq = exp_seq + 8'd1;
`endif
    endtask

    task automatic reset_model();
        exp_drops = 16'h0;
`ifdef ADS124X_SEQ_TAG_EN
        exp_seq = 8'h0;
`endif
    endtask

    task automatic drdy_pulse();
        @(posedge clk); #1 DRDY = 1'b0;
        repeat (3) @(posedge clk);
        #1 DRDY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drops DRDY just after an edge and returns the number of aclk edges until SS_O is seen low.
    task automatic start_frame(input logic [23:0] w, output int lat);
        adc_word = w;
        lat = -1;
        @(posedge clk); #1 DRDY = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 3) DRDY = 1'b1;
            if (!SS_O) begin
                lat = i;
                break;
            end
        end
        DRDY = 1'b1;
    endtask

    task automatic wait_valid(output bit seen, output logic ss_before, output logic ss_at);
        logic last_ss;
        last_ss = SS_O;
        seen = 1'b0;
        ss_before = 1'bx;
        ss_at = 1'bx;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (axis.tvalid) begin
                seen = 1'b1;
                ss_before = last_ss;
                ss_at = SS_O;
                break;
            end
            last_ss = SS_O;
        end
    endtask

    task automatic run_frame(input logic [23:0] w, output int lat, output bit seen,
                             output logic ss_before, output logic ss_at, output logic [31:0] data,
                             output logic valid_next, output logic busy_next);
        axis.tready = 1'b1;
        start_frame(w, lat);
        wait_valid(seen, ss_before, ss_at);
        data = axis.tdata;
        @(posedge clk); #1;
        valid_next = axis.tvalid;
        busy_next = busy;
        if (seen) note_handshake();
        axis.tready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (SS_O !== 1'b1) begin errors++; $display("FAIL reset_ss got %b want 1", SS_O); end
        checks++; if (SCK_O !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", SCK_O); end
        checks++; if (IO0_O !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", IO0_O); end
        checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
        checks++; if (axis.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", axis.tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drops got %h want 0", drop_count); end
    endtask

    task automatic check_clean_frame(input string name, input logic [23:0] w);
        int lat; bit seen; logic ssb, ssa, vn, bn; logic [31:0] data, exp;
        exp = model_sample(w);
        run_frame(w, lat, seen, ssb, ssa, data, vn, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
        checks++; if (!seen) begin errors++; $display("FAIL %s_valid_timeout got 0 want 1", name); end
        checks++; if (data !== exp) begin errors++; $display("FAIL %s_tdata got %h want %h", name, data, exp); end
        checks++; if (ssb !== 1'b0 || ssa !== 1'b1) begin errors++; $display("FAIL %s_ss_at_valid got %b%b want 01", name, ssb, ssa); end
        checks++; if (vn !== 1'b0 || bn !== 1'b0) begin errors++; $display("FAIL %s_single_beat got v=%b busy=%b want 0 0", name, vn, bn); end
        checks++; if (mon_ss_low != 66 * CLK_DIV) begin errors++; $display("FAIL %s_ss_low got %0d want %0d", name, mon_ss_low, 66 * CLK_DIV); end
        checks++; if (mon_mosi !== 32'h12FF_FFFF) begin errors++; $display("FAIL %s_mosi got %h want 12ffffff", name, mon_mosi); end
        checks++; if (mon_rises != 32 || mon_sck_bad != 0) begin errors++; $display("FAIL %s_sck got rises=%0d badhigh=%0d want 32 0", name, mon_rises, mon_sck_bad); end
    endtask

    task automatic test_sign_extension();
        check_clean_frame("sign_ext", 24'h800001);
    endtask

    task automatic test_full_scale();
        check_clean_frame("full_scale", 24'h7FFFFF);
    endtask

    task automatic test_random_frames();
        int lat; bit seen; logic ssb, ssa; logic [23:0] w; logic [31:0] exp; int hold; bit do_drop;
        for (int n = 0; n < 8; n++) begin
            w = 24'($urandom);
            hold = $urandom_range(0, 4);
            do_drop = 1'($urandom);
            exp = model_sample(w);
            axis.tready = 1'b0;
            start_frame(w, lat);
            if (do_drop) begin
                drdy_pulse();
                exp_drops = exp_drops + 16'd1;
            end
            wait_valid(seen, ssb, ssa);
            checks++; if (!seen || axis.tdata !== exp) begin errors++; $display("FAIL rand%0d_tdata got %h want %h", n, axis.tdata, exp); end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checks++; if (axis.tdata !== exp || axis.tvalid !== 1'b1) begin errors++; $display("FAIL rand%0d_hold got %h v=%b want %h v=1", n, axis.tdata, axis.tvalid, exp); end
            end
            axis.tready = 1'b1;
            @(posedge clk); #1;
            axis.tready = 1'b0;
            note_handshake();
            checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rand%0d_release got %b want 0", n, axis.tvalid); end
            checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL rand%0d_drops got %h want %h", n, drop_count, exp_drops); end
        end
    endtask

    task automatic test_backpressure();
        int lat, frames0, beats; bit seen; logic ssb, ssa; logic [23:0] w; logic [31:0] exp;
        w = 24'($urandom);
        exp = model_sample(w);
        axis.tready = 1'b0;
        start_frame(w, lat);
        wait_valid(seen, ssb, ssa);
        frames0 = mon_frames;
        drdy_pulse();
        exp_drops = exp_drops + 16'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL bp_drops got %h want %h", drop_count, exp_drops); end
        checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== exp) begin errors++; $display("FAIL bp_held got %h v=%b want %h v=1", axis.tdata, axis.tvalid, exp); end
        checks++; if (mon_frames != frames0 || SS_O !== 1'b1) begin errors++; $display("FAIL bp_no_frame got frames=%0d ss=%b want %0d 1", mon_frames, SS_O, frames0); end
        axis.tready = 1'b1;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (axis.tvalid && axis.tready) beats++;
        end
        axis.tready = 1'b0;
        note_handshake();
        checks++; if (beats != 1) begin errors++; $display("FAIL bp_beats got %0d want 1", beats); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_enable();
        int frames0;
        enable = 1'b0;
        frames0 = mon_frames;
        for (int i = 0; i < 10; i++) drdy_pulse();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (mon_frames != frames0) begin errors++; $display("FAIL en_off_frames got %0d want %0d", mon_frames, frames0); end
        checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL en_off_drops got %h want %h", drop_count, exp_drops); end
        checks++; if (busy !== 1'b0 || SS_O !== 1'b1) begin errors++; $display("FAIL en_off_idle got busy=%b ss=%b want 0 1", busy, SS_O); end
        enable = 1'b1;
    endtask

    task automatic test_enable_midframe();
        int lat; bit seen; logic ssb, ssa; logic [23:0] w; logic [31:0] exp;
        w = 24'($urandom);
        exp = model_sample(w);
        axis.tready = 1'b1;
        start_frame(w, lat);
        enable = 1'b0;
        drdy_pulse();
        wait_valid(seen, ssb, ssa);
        checks++; if (!seen || axis.tdata !== exp) begin errors++; $display("FAIL en_mid_tdata got %h want %h", axis.tdata, exp); end
        @(posedge clk); #1;
        note_handshake();
        axis.tready = 1'b0;
        checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL en_mid_drops got %h want %h", drop_count, exp_drops); end
        checks++; if (mon_ss_low != 66 * CLK_DIV) begin errors++; $display("FAIL en_mid_ss_low got %0d want %0d", mon_ss_low, 66 * CLK_DIV); end
        enable = 1'b1;
    endtask

    task automatic test_saturation();
        int lat; bit seen; logic ssb, ssa;
        @(negedge clk);
        force dut.drop_q = 16'hFFFC;
        @(negedge clk);
        release dut.drop_q;
        exp_drops = 16'hFFFC;
        axis.tready = 1'b0;
        start_frame(24'($urandom), lat);
        wait_valid(seen, ssb, ssa);
        for (int i = 0; i < 7; i++) begin
            drdy_pulse();
            if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
            if (i == 1 || i == 5 || i == 6) begin
                checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL sat_drops%0d got %h want %h", i, drop_count, exp_drops); end
            end
        end
        axis.tready = 1'b1;
        @(posedge clk); #1;
        axis.tready = 1'b0;
        note_handshake();
    endtask

    task automatic test_reset_mid_shift();
        int lat; bit reached;
        axis.tready = 1'b0;
        start_frame(24'($urandom), lat);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (live_rises >= 13) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("FAIL rst_mid_bit12 got timeout want bit 12"); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (SS_O !== 1'b1 || SCK_O !== 1'b0 || IO0_O !== 1'b0) begin errors++; $display("FAIL rst_mid_spi got ss=%b sck=%b mosi=%b want 1 0 0", SS_O, SCK_O, IO0_O); end
        checks++; if (axis.tvalid !== 1'b0 || axis.tdata !== 32'h0) begin errors++; $display("FAIL rst_mid_axis got v=%b d=%h want 0 0", axis.tvalid, axis.tdata); end
        checks++; if (busy !== 1'b0 || drop_count !== 16'h0) begin errors++; $display("FAIL rst_mid_status got busy=%b drops=%h want 0 0", busy, drop_count); end
        reset_model();
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        check_clean_frame("rst_recover", 24'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        aresetn = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        test_sign_extension();
        test_full_scale();
        test_random_frames();
        test_backpressure();
        test_enable();
        test_enable_midframe();
        test_saturation();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
